// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache, one word per frame.
// Hits return in the request cycle. A miss latches the word address, fetches
// it from RAM while ihit stays low to stall the PC, then fills the frame so
// the repeated fetch hits on the following cycle.
module icache_responder #(
   parameter int SETS  = 16,
   parameter int WORDW = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             imemREN,
   input  logic [WORDW-1:0] imemaddr,
   input  logic             flush,
   output logic             ihit,
   output logic [WORDW-1:0] imemload,
   output logic             iREN,
   output logic [WORDW-1:0] iaddr,
   input  logic             iwait,
   input  logic [WORDW-1:0] iload,
   output logic [31:0]      hitcnt,
   output logic [31:0]      misscnt
);

   localparam int IDXW = $clog2(SETS);
   localparam int TAGW = WORDW - IDXW - 2;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t state;
   state_t next_state;

   // Frame storage; only the valid bits need a reset value.
   logic [SETS-1:0]  valid;
   logic [TAGW-1:0]  tag_mem  [SETS];
   logic [WORDW-1:0] data_mem [SETS];

   // Word address of the fetch in flight; byte-offset bits are implicitly zero.
   logic [WORDW-3:0] fetch_word;

   logic [IDXW-1:0] req_idx;
   logic [TAGW-1:0] req_tag;
   logic [IDXW-1:0] fill_idx;
   logic [TAGW-1:0] fill_tag;
   logic            hit;
   logic            miss_start;
   logic            fill;
   logic            unused_addr_bits;

   assign req_idx  = imemaddr[IDXW+1:2];
   assign req_tag  = imemaddr[WORDW-1:IDXW+2];
   assign fill_idx = fetch_word[IDXW-1:0];
   assign fill_tag = fetch_word[WORDW-3:IDXW];
   assign iaddr    = {fetch_word, 2'b00};

   // Instructions are word aligned, so the byte offset of the PC is dropped.
   assign unused_addr_bits = &{1'b0, imemaddr[1:0]};

   assign hit        = imemREN & valid[req_idx] & (tag_mem[req_idx] == req_tag);
   assign miss_start = (state == IDLE) & imemREN & ~hit & ~flush;
   assign fill       = (state == FETCH) & ~iwait & ~flush;

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state: a flush always abandons an in-flight fetch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (miss_start) begin
               next_state = FETCH;
            end
         end
         FETCH: begin
            if (flush || !iwait) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs: hits only report from IDLE and are masked by a flush.
   always_comb begin
      ihit     = 1'b0;
      imemload = '0;
      iREN     = 1'b0;
      case (state)
         IDLE: begin
            ihit     = hit & ~flush;
            imemload = (hit & ~flush) ? data_mem[req_idx] : '0;
         end
         FETCH: begin
            iREN = 1'b1;
         end
         default: begin
            iREN = 1'b0;
         end
      endcase
   end

   // Miss address latch and the hit/miss performance counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_word <= '0;
         hitcnt     <= '0;
         misscnt    <= '0;
      end else begin
         if (miss_start) begin
            fetch_word <= imemaddr[WORDW-1:2];
            misscnt    <= misscnt + 32'd1;
         end
         if (ihit) begin
            hitcnt <= hitcnt + 32'd1;
         end
      end
   end

   // Valid bits: flush clears everything and beats a same-cycle fill.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (fill) begin
         valid[fill_idx] <= 1'b1;
      end
   end

   // Tag and data arrays are written on a completed fill only.
   always_ff @(posedge CLK) begin
      if (fill) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= iload;
      end
   end

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed test of the instruction cache covering cold
// miss, conflict eviction, hit streaks, flush during a fill, address change
// during a fetch and reset during a fetch.
module tb_icache_responder;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        flush;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hitcnt;
   logic [31:0] misscnt;

   int total = 0;
   int bad   = 0;

   icache_responder #(.SETS(16), .WORDW(32)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .flush    (flush),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .hitcnt   (hitcnt),
      .misscnt  (misscnt)
   );

   // Free-running 10-unit clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance to just after the next rising edge.
   task automatic stepClock();
      @(posedge CLK);
      #1;
   endtask

   // Drive the fetch and RAM-side inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                                input logic wt, input logic [31:0] load,
                                input logic fl);
      imemREN  = ren;
      imemaddr = addr;
      iwait    = wt;
      iload    = load;
      flush    = fl;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string name, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", name, obs, exp);
      end
   endtask

   // Fill one frame through a zero-wait miss, leaving the request idle.
   task automatic fillLine(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(1'b1, addr, 1'b0, data, 1'b0);
      stepClock();
      stepClock();
      applyStimulus(1'b0, addr, 1'b1, 32'h0, 1'b0);
   endtask

   // Directed sequence.
   initial begin
      nRST = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
      #2;
      checkOutput("rst_ihit",     {31'b0, ihit}, 32'h0);
      checkOutput("rst_imemload", imemload,      32'h0);
      checkOutput("rst_iREN",     {31'b0, iREN}, 32'h0);
      checkOutput("rst_iaddr",    iaddr,         32'h0);
      checkOutput("rst_hitcnt",   hitcnt,        32'h0);
      checkOutput("rst_misscnt",  misscnt,       32'h0);
      @(negedge CLK);
      nRST = 1'b1;
      stepClock();

      $display("[TB] 1 cold miss");
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, 1'b0);
      checkOutput("t1_detect_ihit", {31'b0, ihit}, 32'h0);
      checkOutput("t1_detect_iREN", {31'b0, iREN}, 32'h0);
      stepClock();
      checkOutput("t1_wait1_iREN", {31'b0, iREN}, 32'h1);
      checkOutput("t1_iaddr",      iaddr,         32'h40);
      checkOutput("t1_wait1_ihit", {31'b0, ihit}, 32'h0);
      stepClock();
      checkOutput("t1_wait2_iREN", {31'b0, iREN}, 32'h1);
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h8C220004, 1'b0);
      checkOutput("t1_fill_iREN", {31'b0, iREN}, 32'h1);
      stepClock();
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, 1'b0);
      checkOutput("t1_hit_ihit",     {31'b0, ihit}, 32'h1);
      checkOutput("t1_hit_imemload", imemload,      32'h8C220004);
      checkOutput("t1_hit_iREN",     {31'b0, iREN}, 32'h0);
      checkOutput("t1_misscnt",      misscnt,       32'h1);
      stepClock();
      applyStimulus(1'b0, 32'h40, 1'b1, 32'h0, 1'b0);
      checkOutput("t1_hitcnt", hitcnt, 32'h1);

      $display("[TB] 2 conflict");
      applyStimulus(1'b1, 32'h80, 1'b1, 32'h0, 1'b0);
      checkOutput("t2_80_miss", {31'b0, ihit}, 32'h0);
      stepClock();
      checkOutput("t2_80_iaddr",   iaddr,   32'h80);
      checkOutput("t2_80_misscnt", misscnt, 32'h2);
      applyStimulus(1'b1, 32'h80, 1'b0, 32'h11111111, 1'b0);
      stepClock();
      applyStimulus(1'b1, 32'h80, 1'b1, 32'h0, 1'b0);
      checkOutput("t2_80_hit",      {31'b0, ihit}, 32'h1);
      checkOutput("t2_80_imemload", imemload,      32'h11111111);
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, 1'b0);
      checkOutput("t2_40_evicted", {31'b0, ihit}, 32'h0);
      stepClock();
      checkOutput("t2_misscnt", misscnt, 32'h3);
      checkOutput("t2_40_iaddr", iaddr,  32'h40);
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h8C220004, 1'b0);
      stepClock();
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, 1'b0);
      checkOutput("t2_40_refill", imemload, 32'h8C220004);
      applyStimulus(1'b0, 32'h40, 1'b1, 32'h0, 1'b0);
      checkOutput("t2_hitcnt", hitcnt, 32'h1);

      $display("[TB] 3 hit streak");
      fillLine(32'h0, 32'h00000013);
      fillLine(32'h4, 32'h00100093);
      fillLine(32'h8, 32'h00200113);
      checkOutput("t3_prefill_misscnt", misscnt, 32'h6);
      applyStimulus(1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
      checkOutput("t3_0_ihit", {31'b0, ihit}, 32'h1);
      checkOutput("t3_0_data", imemload,      32'h00000013);
      checkOutput("t3_0_iREN", {31'b0, iREN}, 32'h0);
      stepClock();
      applyStimulus(1'b1, 32'h4, 1'b1, 32'h0, 1'b0);
      checkOutput("t3_4_ihit", {31'b0, ihit}, 32'h1);
      checkOutput("t3_4_data", imemload,      32'h00100093);
      checkOutput("t3_4_iREN", {31'b0, iREN}, 32'h0);
      stepClock();
      applyStimulus(1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
      checkOutput("t3_8_ihit", {31'b0, ihit}, 32'h1);
      checkOutput("t3_8_data", imemload,      32'h00200113);
      checkOutput("t3_8_iREN", {31'b0, iREN}, 32'h0);
      stepClock();
      applyStimulus(1'b0, 32'h8, 1'b1, 32'h0, 1'b0);
      checkOutput("t3_hitcnt",  hitcnt,  32'h4);
      checkOutput("t3_misscnt", misscnt, 32'h6);

      $display("[TB] 4 flush mid-fill");
      applyStimulus(1'b1, 32'h10, 1'b1, 32'h0, 1'b0);
      checkOutput("t4_detect", {31'b0, ihit}, 32'h0);
      stepClock();
      checkOutput("t4_fetch_iREN", {31'b0, iREN}, 32'h1);
      applyStimulus(1'b1, 32'h10, 1'b1, 32'h0, 1'b1);
      checkOutput("t4_flush_iREN", {31'b0, iREN}, 32'h1);
      stepClock();
      applyStimulus(1'b1, 32'h10, 1'b1, 32'h0, 1'b0);
      checkOutput("t4_iREN_drop", {31'b0, iREN}, 32'h0);
      checkOutput("t4_remiss",    {31'b0, ihit}, 32'h0);
      stepClock();
      checkOutput("t4_refetch_iREN", {31'b0, iREN}, 32'h1);
      checkOutput("t4_misscnt",      misscnt,       32'h8);
      applyStimulus(1'b1, 32'h10, 1'b0, 32'h00000055, 1'b0);
      stepClock();
      applyStimulus(1'b1, 32'h10, 1'b1, 32'h0, 1'b0);
      checkOutput("t4_refill_ihit", {31'b0, ihit}, 32'h1);
      checkOutput("t4_refill_data", imemload,      32'h00000055);
      applyStimulus(1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
      checkOutput("t4_0_flushed", {31'b0, ihit}, 32'h0);
      applyStimulus(1'b1, 32'h10, 1'b1, 32'h0, 1'b1);
      checkOutput("t4_flush_masks_hit", {31'b0, ihit}, 32'h0);
      checkOutput("t4_flush_masks_data", imemload,     32'h0);
      stepClock();
      applyStimulus(1'b0, 32'h10, 1'b1, 32'h0, 1'b0);
      checkOutput("t4_idle_flush_misscnt", misscnt,       32'h8);
      checkOutput("t4_idle_flush_iREN",    {31'b0, iREN}, 32'h0);
      checkOutput("t4_hitcnt",             hitcnt,        32'h4);
      applyStimulus(1'b1, 32'h10, 1'b1, 32'h0, 1'b0);
      checkOutput("t4_10_invalid", {31'b0, ihit}, 32'h0);
      applyStimulus(1'b0, 32'h10, 1'b1, 32'h0, 1'b0);

      $display("[TB] 5 addr change in FETCH");
      applyStimulus(1'b1, 32'h20, 1'b1, 32'h0, 1'b0);
      stepClock();
      applyStimulus(1'b1, 32'h24, 1'b1, 32'h0, 1'b0);
      checkOutput("t5_iaddr_latched", iaddr,   32'h20);
      checkOutput("t5_misscnt",       misscnt, 32'h9);
      applyStimulus(1'b1, 32'h24, 1'b0, 32'h77777777, 1'b0);
      stepClock();
      applyStimulus(1'b1, 32'h24, 1'b1, 32'h0, 1'b0);
      checkOutput("t5_24_miss", {31'b0, ihit}, 32'h0);
      stepClock();
      checkOutput("t5_24_iaddr",   iaddr,   32'h24);
      checkOutput("t5_24_misscnt", misscnt, 32'hA);
      applyStimulus(1'b1, 32'h24, 1'b0, 32'h00000088, 1'b0);
      stepClock();
      applyStimulus(1'b1, 32'h24, 1'b1, 32'h0, 1'b0);
      checkOutput("t5_24_data", imemload, 32'h00000088);
      applyStimulus(1'b1, 32'h20, 1'b1, 32'h0, 1'b0);
      checkOutput("t5_20_ihit", {31'b0, ihit}, 32'h1);
      checkOutput("t5_20_data", imemload,      32'h77777777);
      applyStimulus(1'b0, 32'h20, 1'b1, 32'h0, 1'b0);

      $display("[TB] 6 reset mid-FETCH");
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h0, 1'b0);
      stepClock();
      checkOutput("t6_fetch_iREN", {31'b0, iREN}, 32'h1);
      checkOutput("t6_misscnt",    misscnt,       32'hB);
      applyStimulus(1'b1, 32'h100, 1'b0, 32'h00000099, 1'b0);
      nRST = 1'b0;
      #1;
      checkOutput("t6_iREN",    {31'b0, iREN}, 32'h0);
      checkOutput("t6_ihit",    {31'b0, ihit}, 32'h0);
      checkOutput("t6_hitcnt",  hitcnt,        32'h0);
      checkOutput("t6_misscnt_clr", misscnt,   32'h0);
      checkOutput("t6_iaddr",   iaddr,         32'h0);
      stepClock();
      applyStimulus(1'b0, 32'h100, 1'b1, 32'h0, 1'b0);
      nRST = 1'b1;
      #1;
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h0, 1'b0);
      checkOutput("t6_no_fill", {31'b0, ihit}, 32'h0);
      applyStimulus(1'b1, 32'h20, 1'b1, 32'h0, 1'b0);
      checkOutput("t6_valid_cleared", {31'b0, ihit}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
